// File: rtl/ret_rti_unstack_pkg.sv
// Shared processor definitions used by the RET/RTI unstack sequencer.
package ret_rti_unstack_pkg;

  localparam int STACK_W = 16;
  localparam int ADDR_W  = 32;
  localparam int CCR_W   = 3;

  // Unstack sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP_LO  = 3'd1,
    ST_POP_HI  = 3'd2,
    ST_POP_CCR = 3'd3,
    ST_FINISH  = 3'd4
  } unstack_state_e;

  // Which return instruction started the active sequence.
  typedef enum logic {
    KIND_RET = 1'b0,
    KIND_RTI = 1'b1
  } ret_kind_e;

endpackage

// File: rtl/ret_rti_unstack.sv
// RET/RTI unstack sequencer: pops PC (and CCR for RTI) from the downward
// growing stack one 16-bit word per cycle, then loads PC/CCR/SP in one shot.
module ret_rti_unstack
  import ret_rti_unstack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ret,
  input  logic              rti,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic [STACK_W-1:0] mem_rdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_we,
  output logic [CCR_W-1:0]  ccr_out,
  output logic              ccr_we,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_we,
  output logic              busy
);

  unstack_state_e     state_q, state_d;
  ret_kind_e          kind_q;
  logic [ADDR_W-1:0]  sp_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [CCR_W-1:0]   ccr_q;
  logic               trigger;

  // Triggers are only looked at while idle; anything during a sequence is dropped.
  assign trigger = (state_q == ST_IDLE) && (ret || rti);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RET skips the CCR pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (ret || rti) state_d = ST_POP_LO;
      ST_POP_LO:  state_d = ST_POP_HI;
      ST_POP_HI:  state_d = (kind_q == KIND_RTI) ? ST_POP_CCR : ST_FINISH;
      ST_POP_CCR: state_d = ST_FINISH;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath captures: read data arrives one cycle after its strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      pc_q   <= '0;
      ccr_q  <= '0;
      kind_q <= KIND_RET;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            sp_q   <= sp_in;
            kind_q <= rti ? KIND_RTI : KIND_RET;
          end
        end
        ST_POP_HI:  pc_q[STACK_W-1:0]      <= mem_rdata;
        ST_POP_CCR: pc_q[ADDR_W-1:STACK_W] <= mem_rdata;
        ST_FINISH: begin
          if (kind_q == KIND_RTI) begin
            ccr_q <= mem_rdata[CCR_W-1:0];
          end else begin
            pc_q[ADDR_W-1:STACK_W] <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: everything is zero unless the current state drives it, so an
  // asynchronous reset clears all outputs immediately.
  always_comb begin
    mem_re   = 1'b0;
    mem_addr = '0;
    pc_out   = '0;
    pc_we    = 1'b0;
    ccr_out  = '0;
    ccr_we   = 1'b0;
    sp_out   = '0;
    sp_we    = 1'b0;
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_POP_LO: begin
        mem_re   = 1'b1;
        mem_addr = sp_q + ADDR_W'(1);
      end
      ST_POP_HI: begin
        mem_re   = 1'b1;
        mem_addr = sp_q + ADDR_W'(2);
      end
      ST_POP_CCR: begin
        mem_re   = 1'b1;
        mem_addr = sp_q + ADDR_W'(3);
      end
      ST_FINISH: begin
        // The last popped word is still on mem_rdata; forward it so the
        // loads happen in this cycle rather than one later.
        pc_we = 1'b1;
        sp_we = 1'b1;
        if (kind_q == KIND_RTI) begin
          pc_out  = pc_q;
          ccr_out = mem_rdata[CCR_W-1:0];
          ccr_we  = 1'b1;
          sp_out  = sp_q + ADDR_W'(3);
        end else begin
          pc_out  = {mem_rdata, pc_q[STACK_W-1:0]};
          ccr_out = ccr_q;
          sp_out  = sp_q + ADDR_W'(2);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ret_rti_unstack.sv
// Self-checking bench for ret_rti_unstack: directed cases plus randomized
// sequences, compared against a transaction-level model of the unstack.
module tb_ret_rti_unstack;

  logic        clk = 1'b0;
  logic        rst;
  logic        ret;
  logic        rti;
  logic [31:0] sp_in;
  logic [15:0] mem_rdata;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] pc_out;
  logic        pc_we;
  logic [2:0]  ccr_out;
  logic        ccr_we;
  logic [31:0] sp_out;
  logic        sp_we;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  ret_rti_unstack dut (
    .clk(clk), .rst(rst), .ret(ret), .rti(rti), .sp_in(sp_in),
    .mem_rdata(mem_rdata), .mem_re(mem_re), .mem_addr(mem_addr),
    .pc_out(pc_out), .pc_we(pc_we), .ccr_out(ccr_out), .ccr_we(ccr_we),
    .sp_out(sp_out), .sp_we(sp_we), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Word-addressed data memory; unwritten locations return an address hash.
  logic [15:0] mem [logic [31:0]];

  function automatic logic [15:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ a[31:16] ^ 16'h5A5A;
  endfunction

  // Synchronous read port: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= rd(mem_addr);
    else        mem_rdata <= 16'hDEAD;
  end

  // Transaction model: a sequence is m_len cycles long (3 for RET, 4 for RTI),
  // reads sp+1.. in its first m_len-1 cycles and commits in its last cycle.
  int          m_len = 0;
  int          m_pos = 0;
  bit          m_rti = 0;
  logic [31:0] m_sp  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_len = 0;
    end else if (m_len == 0) begin
      if (ret || rti) begin
        m_len = rti ? 4 : 3;
        m_rti = rti;
        m_sp  = sp_in;
        m_pos = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == m_len) m_len = 0;
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    logic        last;
    logic [15:0] w1, w2, w3;
    chk("mon_noX", 32'($isunknown({mem_re, mem_addr, pc_out, pc_we, ccr_out,
                                   ccr_we, sp_out, sp_we, busy})), 32'd0);
    chk("mon_busy", busy, m_len != 0);
    if (m_len != 0) begin
      last = (m_pos == m_len - 1);
      w1 = rd(m_sp + 32'd1);
      w2 = rd(m_sp + 32'd2);
      w3 = rd(m_sp + 32'd3);
      chk("mon_re", mem_re, !last);
      if (!last) chk("mon_addr", mem_addr, m_sp + 32'(m_pos) + 32'd1);
      chk("mon_pc_we", pc_we, last);
      chk("mon_sp_we", sp_we, last);
      chk("mon_ccr_we", ccr_we, last && m_rti);
      if (last) begin
        chk("mon_pc", pc_out, {w2, w1});
        chk("mon_sp", sp_out, m_sp + (m_rti ? 32'd3 : 32'd2));
        if (m_rti) chk("mon_ccr", ccr_out, w3[2:0]);
      end
    end else begin
      chk("mon_idle_strobes", {mem_re, pc_we, ccr_we, sp_we}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one RET/RTI, wait (bounded) for the commit cycle, check it.
  task automatic run_seq(input bit r, input bit i, input logic [31:0] sp,
                         input logic [31:0] exp_pc, input logic [2:0] exp_ccr,
                         input logic [31:0] exp_sp, input int exp_lat,
                         input bit extra_pulse);
    int cyc;
    int we_cnt;
    bit found;
    ret = r; rti = i; sp_in = sp;
    tick();
    ret = 0; rti = 0; sp_in = $urandom;
    cyc = 1; we_cnt = 0; found = 0;
    while (!found && cyc <= 8) begin
      if (extra_pulse && cyc == 2) ret = 1;
      else ret = 0;
      if (pc_we) begin
        found = 1;
        we_cnt++;
        chk("latency", cyc, exp_lat);
        chk("pc_out", pc_out, exp_pc);
        chk("sp_out", sp_out, exp_sp);
        chk("ccr_we", ccr_we, i);
        if (i) chk("ccr_out", ccr_out, exp_ccr);
      end else begin
        tick();
        cyc++;
      end
    end
    ret = 0;
    if (!found) chk("commit_timeout", 32'd0, 32'd1);
    tick();
    chk("busy_after", busy, 32'd0);
    if (extra_pulse) begin
      for (int k = 0; k < 4; k++) begin
        if (pc_we) we_cnt++;
        tick();
      end
      chk("pc_we_count", we_cnt, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] sp;
    logic [15:0] v1, v2, v3;
    bit r, i;
    rst = 0; ret = 0; rti = 0; sp_in = '0;
    #1 rst = 1;
    #1;
    chk("rst_busy", busy, 32'd0);
    chk("rst_strobes", {mem_re, pc_we, ccr_we, sp_we}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_sp", sp_out, 32'd0);
    tick(); tick();
    rst = 0;
    tick();

    // RET from 0x7FA.
    mem[32'h7FB] = 16'h1234; mem[32'h7FC] = 16'h0040;
    run_seq(1, 0, 32'h7FA, 32'h0040_1234, 3'd0, 32'h7FC, 3, 0);

    // RTI from 0x7F9, issued back-to-back in the idle cycle after the commit.
    mem[32'h7FA] = 16'hBEEF; mem[32'h7FB] = 16'h0001; mem[32'h7FC] = 16'h0005;
    run_seq(0, 1, 32'h7F9, 32'h0001_BEEF, 3'b101, 32'h7FC, 4, 0);

    // RET and RTI together: the RTI sequence wins.
    mem[32'h101] = 16'hAAAA; mem[32'h102] = 16'h5555; mem[32'h103] = 16'h0002;
    run_seq(1, 1, 32'h100, 32'h5555_AAAA, 3'b010, 32'h103, 4, 0);

    // RET re-pulsed during POP_HI must be ignored.
    mem[32'h201] = 16'h0F0F; mem[32'h202] = 16'hF0F0;
    run_seq(1, 0, 32'h200, 32'hF0F0_0F0F, 3'd0, 32'h202, 3, 1);

    // Stack pointer wrap.
    mem[32'h0] = 16'hCAFE; mem[32'h1] = 16'h8000;
    run_seq(1, 0, 32'hFFFF_FFFF, 32'h8000_CAFE, 3'd0, 32'h1, 3, 0);

    // Reset in POP_CCR aborts the sequence with no commit.
    rti = 1; sp_in = 32'h300;
    tick();
    rti = 0;
    tick(); tick();
    chk("pre_rst_addr", mem_addr, 32'h303);
    #1 rst = 1;
    #1;
    chk("abort_busy", busy, 32'd0);
    chk("abort_outs", {mem_re, pc_we, ccr_we, sp_we}, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    chk("abort_pc", pc_out, 32'd0);
    tick();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_strobes", {busy, mem_re, pc_we, ccr_we, sp_we}, 32'd0);
    end

    // Randomized sequences with random spacing and spurious pulses.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 1);
      i = $urandom_range(0, 1);
      if (!r && !i) r = 1;
      sp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : $urandom;
      v1 = $urandom; v2 = $urandom; v3 = $urandom;
      mem[sp + 32'd1] = v1; mem[sp + 32'd2] = v2; mem[sp + 32'd3] = v3;
      run_seq(r, i, sp, {v2, v1}, v3[2:0], sp + (i ? 32'd3 : 32'd2),
              i ? 4 : 3, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
